// File: rtl/bit_index_iterator_pkg.sv
// Shared types for the bit index iterator.
package bit_iter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } bit_iter_state_t;

endpackage

// File: rtl/bit_index_iterator_if.sv
// Load and index stream signals of the bit index iterator.
// The master side offers vectors and consumes indices; the slave side is the iterator.
interface bit_index_iterator_if #(
  parameter int WIDTH = 8
);
  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_vec;
  logic             load_msb_first;
  logic             abort;
  logic             idx_valid;
  logic             idx_ready;
  logic [IDXW-1:0]  idx;
  logic             idx_last;
  logic [CNTW-1:0]  count;
  logic             empty_pulse;

  modport master (
    output load_valid, load_vec, load_msb_first, abort, idx_ready,
    input  load_ready, idx_valid, idx, idx_last, count, empty_pulse
  );

  modport slave (
    input  load_valid, load_vec, load_msb_first, abort, idx_ready,
    output load_ready, idx_valid, idx, idx_last, count, empty_pulse
  );
endinterface

// File: rtl/bit_index_iterator_priority_pick.sv
// Directional priority pick: index of the lowest (msb_first=0) or
// highest (msb_first=1) set bit of vec; 0 when vec is all zero.
module priority_pick #(
  parameter int WIDTH = 8,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             msb_first,
  output logic [IDXW-1:0]  index
);

  // One scan for both directions: the last hit wins, so walking upward
  // yields the highest set bit and walking downward yields the lowest.
  always_comb begin
    int j;
    index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      j = msb_first ? i : (WIDTH - 1 - i);
      if (vec[j]) index = IDXW'(j);
    end
  end

endmodule

// File: rtl/bit_index_iterator.sv
// Bit index iterator: loads a WIDTH-bit vector and streams out the index
// of each set bit, one per accepted beat, in the direction chosen per load.
module bit_index_iterator
  import bit_iter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  bit_index_iterator_if.slave  bus
);

  localparam int IDXW = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);

  bit_iter_state_t  state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             dir_q, dir_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             empty_q, empty_d;

  logic [IDXW-1:0]  pick_idx;
  logic [WIDTH-1:0] pick_onehot;
  logic             single_bit;
  logic             emitting;

  priority_pick #(.WIDTH(WIDTH)) u_pick (
    .vec       (mask_q),
    .msb_first (dir_q),
    .index     (pick_idx)
  );

  // Decode the picked index into the bit to clear on acceptance.
  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pick_onehot[i] = (pick_idx == IDXW'(i));
    end
  end

  assign emitting   = (state_q == EMIT);
  assign single_bit = ((mask_q & (mask_q - WIDTH'(1))) == '0);

  // Next-state: abort overrides everything; otherwise load in IDLE, consume in EMIT.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dir_d   = dir_q;
    count_d = count_q;
    empty_d = 1'b0;
    if (bus.abort) begin
      state_d = IDLE;
      mask_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            mask_d  = bus.load_vec;
            dir_d   = bus.load_msb_first;
            count_d = '0;
            if (bus.load_vec != '0) state_d = EMIT;
            else                    empty_d = 1'b1;
          end
        end
        EMIT: begin
          if (bus.idx_ready) begin
            mask_d  = mask_q & ~pick_onehot;
            count_d = count_q + CNTW'(1);
            if (single_bit) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dir_q   <= 1'b0;
      count_q <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  assign bus.load_ready  = (state_q == IDLE);
  assign bus.idx_valid   = emitting;
  assign bus.idx         = emitting ? pick_idx : '0;
  assign bus.idx_last    = emitting && single_bit;
  assign bus.count       = count_q;
  assign bus.empty_pulse = empty_q;

endmodule

// File: tb/tb_bit_index_iterator.sv
// Directed bench for bit_index_iterator at WIDTH 8, 5 and 16.
module tb_bit_index_iterator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  bit_index_iterator_if #(.WIDTH(8))  b8 ();
  bit_index_iterator_if #(.WIDTH(5))  b5 ();
  bit_index_iterator_if #(.WIDTH(16)) b16 ();

  bit_index_iterator #(.WIDTH(8))  u8  (.clk(clk), .reset_n(reset_n), .bus(b8));
  bit_index_iterator #(.WIDTH(5))  u5  (.clk(clk), .reset_n(reset_n), .bus(b5));
  bit_index_iterator #(.WIDTH(16)) u16 (.clk(clk), .reset_n(reset_n), .bus(b16));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_msb [4];
    exp_msb = '{7, 5, 2, 0};

    b8.load_valid = 0;  b8.load_vec = '0;  b8.load_msb_first = 0;  b8.abort = 0;  b8.idx_ready = 0;
    b5.load_valid = 0;  b5.load_vec = '0;  b5.load_msb_first = 0;  b5.abort = 0;  b5.idx_ready = 0;
    b16.load_valid = 0; b16.load_vec = '0; b16.load_msb_first = 0; b16.abort = 0; b16.idx_ready = 0;

    // Reset values
    repeat (3) tick();
    chk("rst_load_ready", 32'(b8.load_ready), 1);
    chk("rst_idx_valid", 32'(b8.idx_valid), 0);
    chk("rst_idx", 32'(b8.idx), 0);
    chk("rst_idx_last", 32'(b8.idx_last), 0);
    chk("rst_count", 32'(b8.count), 0);
    chk("rst_empty", 32'(b8.empty_pulse), 0);
    reset_n = 1;
    tick();

    // LSB-first, full throughput
    b8.load_valid = 1; b8.load_vec = 8'b1010_0101; b8.load_msb_first = 0; b8.idx_ready = 1;
    tick();
    b8.load_valid = 0;
    chk("lsb_v0", 32'(b8.idx_valid), 1);
    chk("lsb_lr0", 32'(b8.load_ready), 0);
    chk("lsb_i0", 32'(b8.idx), 0);
    chk("lsb_l0", 32'(b8.idx_last), 0);
    tick();
    chk("lsb_i1", 32'(b8.idx), 2);
    chk("lsb_c1", 32'(b8.count), 1);
    chk("lsb_l1", 32'(b8.idx_last), 0);
    tick();
    chk("lsb_i2", 32'(b8.idx), 5);
    chk("lsb_l2", 32'(b8.idx_last), 0);
    tick();
    chk("lsb_i3", 32'(b8.idx), 7);
    chk("lsb_l3", 32'(b8.idx_last), 1);
    chk("lsb_c3", 32'(b8.count), 3);
    tick();
    chk("lsb_done_v", 32'(b8.idx_valid), 0);
    chk("lsb_done_lr", 32'(b8.load_ready), 1);
    chk("lsb_done_c", 32'(b8.count), 4);
    chk("lsb_done_idx", 32'(b8.idx), 0);

    // MSB-first with alternating backpressure
    b8.load_valid = 1; b8.load_vec = 8'b1010_0101; b8.load_msb_first = 1; b8.idx_ready = 0;
    tick();
    b8.load_valid = 0;
    for (int k = 0; k < 4; k++) begin
      chk("msb_idx", 32'(b8.idx), 32'(exp_msb[k]));
      chk("msb_last", 32'(b8.idx_last), (k == 3) ? 1 : 0);
      chk("msb_cnt", 32'(b8.count), 32'(k));
      b8.idx_ready = 0;
      tick();
      chk("msb_stall_v", 32'(b8.idx_valid), 1);
      chk("msb_stall_idx", 32'(b8.idx), 32'(exp_msb[k]));
      chk("msb_stall_cnt", 32'(b8.count), 32'(k));
      b8.idx_ready = 1;
      tick();
    end
    chk("msb_done_v", 32'(b8.idx_valid), 0);
    chk("msb_done_c", 32'(b8.count), 4);
    chk("msb_done_lr", 32'(b8.load_ready), 1);

    // Empty vector
    b8.load_valid = 1; b8.load_vec = 8'h00; b8.load_msb_first = 0;
    tick();
    b8.load_valid = 0;
    chk("empty_pulse_hi", 32'(b8.empty_pulse), 1);
    chk("empty_no_valid", 32'(b8.idx_valid), 0);
    chk("empty_lr", 32'(b8.load_ready), 1);
    chk("empty_count", 32'(b8.count), 0);
    tick();
    chk("empty_pulse_lo", 32'(b8.empty_pulse), 0);
    chk("empty_no_valid2", 32'(b8.idx_valid), 0);

    // Single set bit
    b8.load_valid = 1; b8.load_vec = 8'h80; b8.load_msb_first = 0; b8.idx_ready = 1;
    tick();
    b8.load_valid = 0;
    chk("single_idx", 32'(b8.idx), 7);
    chk("single_last", 32'(b8.idx_last), 1);
    tick();
    chk("single_done_v", 32'(b8.idx_valid), 0);
    chk("single_count", 32'(b8.count), 1);

    // Abort during emission, coincident with a handshake
    b8.load_valid = 1; b8.load_vec = 8'hFF; b8.load_msb_first = 0; b8.idx_ready = 1;
    tick();
    b8.load_valid = 0;
    chk("abort_i0", 32'(b8.idx), 0);
    tick();
    chk("abort_i1", 32'(b8.idx), 1);
    tick();
    chk("abort_i2", 32'(b8.idx), 2);
    tick();
    chk("abort_i3", 32'(b8.idx), 3);
    chk("abort_pre_c", 32'(b8.count), 3);
    b8.abort = 1;
    tick();
    chk("abort_v", 32'(b8.idx_valid), 0);
    chk("abort_lr", 32'(b8.load_ready), 1);
    chk("abort_c", 32'(b8.count), 3);
    chk("abort_idx", 32'(b8.idx), 0);
    // Abort in IDLE drops a coincident load
    b8.load_valid = 1; b8.load_vec = 8'hFF;
    tick();
    b8.abort = 0; b8.load_valid = 0;
    chk("abort_idle_v", 32'(b8.idx_valid), 0);
    chk("abort_idle_lr", 32'(b8.load_ready), 1);
    chk("abort_idle_c", 32'(b8.count), 3);
    chk("abort_idle_empty", 32'(b8.empty_pulse), 0);

    // Asynchronous reset mid-iteration
    b8.load_valid = 1; b8.load_vec = 8'h0F; b8.load_msb_first = 0; b8.idx_ready = 1;
    tick();
    b8.load_valid = 0;
    tick();
    chk("mid_pre_idx", 32'(b8.idx), 1);
    chk("mid_pre_c", 32'(b8.count), 1);
    reset_n = 0;
    #1;
    chk("mid_rst_v", 32'(b8.idx_valid), 0);
    chk("mid_rst_lr", 32'(b8.load_ready), 1);
    chk("mid_rst_c", 32'(b8.count), 0);
    chk("mid_rst_idx", 32'(b8.idx), 0);
    tick();
    reset_n = 1;
    tick();
    chk("post_rst_v", 32'(b8.idx_valid), 0);
    chk("post_rst_lr", 32'(b8.load_ready), 1);
    chk("post_rst_c", 32'(b8.count), 0);

    // WIDTH=5
    b5.load_valid = 1; b5.load_vec = 5'b10001; b5.load_msb_first = 0; b5.idx_ready = 1;
    tick();
    b5.load_valid = 0;
    chk("w5_i0", 32'(b5.idx), 0);
    chk("w5_l0", 32'(b5.idx_last), 0);
    tick();
    chk("w5_i1", 32'(b5.idx), 4);
    chk("w5_l1", 32'(b5.idx_last), 1);
    tick();
    chk("w5_done_v", 32'(b5.idx_valid), 0);
    chk("w5_done_c", 32'(b5.count), 2);

    // WIDTH=16, MSB-first
    b16.load_valid = 1; b16.load_vec = 16'h8001; b16.load_msb_first = 1; b16.idx_ready = 1;
    tick();
    b16.load_valid = 0;
    chk("w16_i0", 32'(b16.idx), 15);
    chk("w16_l0", 32'(b16.idx_last), 0);
    tick();
    chk("w16_i1", 32'(b16.idx), 0);
    chk("w16_l1", 32'(b16.idx_last), 1);
    tick();
    chk("w16_done_v", 32'(b16.idx_valid), 0);
    chk("w16_done_c", 32'(b16.count), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
